// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: packs four consecutive UART bytes (MSB first) into one
// 32-bit command word. An inter-byte timeout drops partial frames so the byte
// stream realigns after glitches or lost bytes.
//
// Handshake: rx_valid has no ready; every cycle with rx_valid high delivers
// exactly one byte, which is always accepted. uart_ready and frame_err are
// registered one-cycle strobes and are never high together.
module uart_frame_assembler #(
  parameter logic [31:0] TIMEOUT_CNT = 32'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] uart_reg,
  output logic        uart_ready,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t      state, state_nx;
  logic [1:0]  count, count_nx;
  logic [23:0] shift, shift_nx;
  logic [31:0] timer, timer_nx;
  logic [31:0] reg_nx;
  logic        ready_nx, err_nx;
  logic [31:0] word;

  // The frame as it would stand if the current byte is accepted
  assign word = {shift, rx_data};

  // busy mirrors the FSM state so the state is observable at the port
  assign busy = (state == S_RECV);

  // State, counters, shift register and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      count      <= 2'd0;
      shift      <= 24'h0;
      timer      <= 32'h0;
      uart_reg   <= 32'h0;
      uart_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      shift      <= shift_nx;
      timer      <= timer_nx;
      uart_reg   <= reg_nx;
      uart_ready <= ready_nx;
      frame_err  <= err_nx;
    end
  end

  // Next-state logic: byte accumulation, frame completion and timeout
  always_comb begin
    state_nx = state;
    count_nx = count;
    shift_nx = shift;
    timer_nx = timer;
    reg_nx   = uart_reg;
    ready_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        count_nx = 2'd0;
        timer_nx = 32'h0;
        if (rx_valid) begin
          shift_nx = word[23:0];
          count_nx = 2'd1;
          state_nx = S_RECV;
        end
      end
      S_RECV: begin
        if (rx_valid) begin
          // A byte on the last permitted idle cycle still belongs to this frame
          shift_nx = word[23:0];
          timer_nx = 32'h0;
          if (count == 2'd3) begin
            reg_nx   = word;
            ready_nx = 1'b1;
            count_nx = 2'd0;
            state_nx = S_IDLE;
          end else begin
            count_nx = count + 2'd1;
          end
        end else if (timer >= TIMEOUT_CNT - 32'd1) begin
          // This is the TIMEOUT_CNT-th idle cycle: drop the partial frame
          err_nx   = 1'b1;
          count_nx = 2'd0;
          timer_nx = 32'h0;
          state_nx = S_IDLE;
        end else begin
          timer_nx = timer + 32'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        count_nx = 2'd0;
        timer_nx = 32'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: a vector table for streaming frames plus
// hand-written sequences for timeout, reset and realignment corner cases.
// Completed words are checked by a scoreboard queue.
module tb_uart_frame_assembler;

  localparam logic [31:0] TO = 32'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] uart_reg;
  logic        uart_ready;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int rdy_cnt = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        ferr;
    logic        bsy;
    logic [31:0] reg_val;
  } vec_t;

  vec_t vecs[16];

  uart_frame_assembler #(.TIMEOUT_CNT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .uart_reg(uart_reg),
    .uart_ready(uart_ready),
    .frame_err(frame_err),
    .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; returns #1 after the edge with outputs settled
  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  // scoreboard: every uart_ready strobe must match the oldest expected word
  always @(negedge clk) begin
    if (uart_ready) begin
      rdy_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected no frame at %0t", uart_reg, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (uart_reg !== e) begin
          errors++;
          $display("FAIL sb_word: got %h expected %h at %0t", uart_reg, e, $time);
        end
      end
    end
    if (frame_err) err_cnt++;
    if (uart_ready && frame_err) begin
      checks++;
      errors++;
      $display("FAIL strobe_excl: got ready=1 err=1 expected not both at %0t", $time);
    end
  end

  initial begin
    int e0, r0;
    logic [31:0] held;
    logic [7:0] b;

    // table: frame DA CA FF 05, back-to-back 11..18, held-high 5A x4
    vecs[0]  = '{1'b1, 8'hDA, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 8'hCA, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 32'hDACAFF05};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'hDACAFF05};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 32'hDACAFF05};
    vecs[6]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 32'hDACAFF05};
    vecs[7]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 32'hDACAFF05};
    vecs[8]  = '{1'b1, 8'h14, 1'b1, 1'b0, 1'b0, 32'h11121314};
    vecs[9]  = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 32'h11121314};
    vecs[10] = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b1, 32'h11121314};
    vecs[11] = '{1'b1, 8'h17, 1'b0, 1'b0, 1'b1, 32'h11121314};
    vecs[12] = '{1'b1, 8'h18, 1'b1, 1'b0, 1'b0, 32'h15161718};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h15161718};
    vecs[14] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 32'h15161718};
    vecs[15] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 32'h15161718};

    // reset
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_reg", uart_reg, 32'h0);
    chk("rst_ready", {31'b0, uart_ready}, 32'h0);
    chk("rst_ferr", {31'b0, frame_err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;

    // table-driven streaming frames
    exp_q.push_back(32'hDACAFF05);
    exp_q.push_back(32'h11121314);
    exp_q.push_back(32'h15161718);
    exp_q.push_back(32'h5A5A5A5A);
    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_ready", i), {31'b0, uart_ready}, {31'b0, vecs[i].rdy});
      chk($sformatf("vec%0d_ferr", i), {31'b0, frame_err}, {31'b0, vecs[i].ferr});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].bsy});
      chk($sformatf("vec%0d_reg", i), uart_reg, vecs[i].reg_val);
    end
    // remaining two 5A bytes of the held-high frame
    r0 = rdy_cnt;
    tick(1'b1, 8'h5A);
    tick(1'b1, 8'h5A);
    chk("held_ready", {31'b0, uart_ready}, 32'h1);
    chk("held_reg", uart_reg, 32'h5A5A5A5A);
    idle(2);
    chk("held_one_strobe", rdy_cnt - r0, 32'd1);

    // bytes spaced TO cycles apart: the last legal cycle is still accepted
    e0 = err_cnt;
    exp_q.push_back(32'hDACA0010);
    tick(1'b1, 8'hDA);
    b = 8'hCA;
    for (int k = 0; k < 3; k++) begin
      idle(int'(TO) - 1);
      chk($sformatf("gap%0d_busy", k), {31'b0, busy}, 32'h1);
      tick(1'b1, b);
      b = (k == 0) ? 8'h00 : 8'h10;
    end
    chk("gap_ready", {31'b0, uart_ready}, 32'h1);
    chk("gap_reg", uart_reg, 32'hDACA0010);
    chk("gap_no_err", err_cnt - e0, 32'd0);

    // timeout: DA,CA then silence; pulse TO+1 cycles after byte 1
    held = uart_reg;
    tick(1'b1, 8'hDA);
    tick(1'b1, 8'hCA);
    for (int k = 1; k <= int'(TO) + 1; k++) begin
      tick(1'b0, 8'h00);
      chk($sformatf("to%0d_ferr", k), {31'b0, frame_err}, {31'b0, (k == int'(TO))});
      chk($sformatf("to%0d_busy", k), {31'b0, busy}, {31'b0, (k < int'(TO))});
      chk($sformatf("to%0d_reg", k), uart_reg, held);
    end

    // reset mid-frame: no error, outputs cleared, next frame clean
    e0 = err_cnt;
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hBB);
    rst_n = 1'b0;
    tick(1'b0, 8'h00);
    rst_n = 1'b1;
    chk("mrst_reg", uart_reg, 32'h0);
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    chk("mrst_ready", {31'b0, uart_ready}, 32'h0);
    idle(int'(TO) + 4);
    chk("mrst_no_err", err_cnt - e0, 32'd0);
    exp_q.push_back(32'h01020304);
    for (int k = 1; k <= 4; k++) tick(1'b1, 8'(k));
    chk("mrst_frame", uart_reg, 32'h01020304);

    // long gap: one error, uart_reg held, then realigned frame
    e0 = err_cnt;
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hBB);
    idle(20);
    chk("lgap_one_err", err_cnt - e0, 32'd1);
    chk("lgap_held", uart_reg, 32'h01020304);
    exp_q.push_back(32'h11223344);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    tick(1'b1, 8'h44);
    chk("lgap_frame", uart_reg, 32'h11223344);

    // byte in the frame_err cycle starts a new frame
    tick(1'b1, 8'hCC);
    idle(int'(TO));
    chk("realign_ferr", {31'b0, frame_err}, 32'h1);
    exp_q.push_back(32'h31323334);
    tick(1'b1, 8'h31);
    chk("realign_busy", {31'b0, busy}, 32'h1);
    tick(1'b1, 8'h32);
    tick(1'b1, 8'h33);
    tick(1'b1, 8'h34);
    chk("realign_frame", uart_reg, 32'h31323334);
    idle(3);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
